// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state type, timeout default and one-hot helpers
package cache_ctrl_pkg;

    // Helpers work on a fixed wide vector; callers zero-extend their way vectors.
    localparam int MAX_WAYS               = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WRITEBACK,
        FILL,
        ALLOC
    } seqState_t;

    function automatic logic isOneHot(input logic [MAX_WAYS-1:0] v);
        return (v != '0) && ((v & (v - MAX_WAYS'(1))) == '0);
    endfunction

    function automatic logic [MAX_WAYS-1:0] lowestSetOneHot(input logic [MAX_WAYS-1:0] v);
        return v & (~v + MAX_WAYS'(1));
    endfunction

endpackage

// File: rtl/way_priority_select.sv
// rtl/way_priority_select.sv - combinational lowest-index way selector
module way_priority_select
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-1:0] candidates,
    output logic [NUM_WAYS-1:0] selected
);

    always_comb begin
        selected = NUM_WAYS'(lowestSetOneHot(MAX_WAYS'(candidates)));
    end

endmodule

// File: rtl/cache_miss_sequencer.sv
// rtl/cache_miss_sequencer.sv - hit notification, victim choice, writeback and line-fill sequencing
module cache_miss_sequencer
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS       = 4,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic [ADDRESS_WIDTH-1:0] reqAddr,
    input  logic [NUM_WAYS-1:0]      reqHitWay,
    input  logic [NUM_WAYS-1:0]      validWays,
    input  logic [NUM_WAYS-1:0]      dirtyWays,
    output logic [NUM_WAYS-1:0]      hitWay,
    output logic [NUM_WAYS-1:0]      allocateWay,
    input  logic [NUM_WAYS-1:0]      evictionTarget,
    input  logic                     evictionReady,
    output logic [NUM_WAYS-1:0]      victimWay,
    output logic                     wbValid,
    input  logic                     wbReady,
    output logic                     fillValid,
    output logic [ADDRESS_WIDTH-1:0] fillAddr,
    input  logic                     fillDone,
    output logic                     respValid,
    output logic                     respHit,
    output logic [NUM_WAYS-1:0]      respWay,
    output logic [2:0]               errFlags
);

    localparam int RR_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    seqState_t state, nextState;

    logic [ADDRESS_WIDTH-1:0] addrQ;
    logic [NUM_WAYS-1:0]      dirtyQ;
    logic [NUM_WAYS-1:0]      victimQ;
    logic [NUM_WAYS-1:0]      hitQ;
    logic [CNT_W-1:0]         waitCnt;
    logic [RR_W-1:0]          rrPtr;
    logic [2:0]               errQ;

    logic                accept;
    logic                isHit;
    logic                hitMulti;
    logic                anyInvalid;
    logic                targetOk;
    logic                timedOut;
    logic                selDone;
    logic [NUM_WAYS-1:0] hitSel;
    logic [NUM_WAYS-1:0] invalidSel;
    logic [NUM_WAYS-1:0] rrWay;
    logic [NUM_WAYS-1:0] selVictim;

    way_priority_select #(.NUM_WAYS(NUM_WAYS)) uHitSel (
        .candidates (reqHitWay),
        .selected   (hitSel)
    );

    way_priority_select #(.NUM_WAYS(NUM_WAYS)) uInvalidSel (
        .candidates (~validWays),
        .selected   (invalidSel)
    );

    always_comb begin
        accept     = reqValid && (state == IDLE);
        isHit      = (reqHitWay != '0);
        hitMulti   = isHit && !isOneHot(MAX_WAYS'(reqHitWay));
        anyInvalid = (invalidSel != '0);
        rrWay      = NUM_WAYS'(1) << rrPtr;
        targetOk   = evictionReady && isOneHot(MAX_WAYS'(evictionTarget));
        // A valid policy answer on the last wait cycle still wins over the fallback.
        timedOut   = !targetOk && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
        selDone    = targetOk || timedOut;
        selVictim  = targetOk ? evictionTarget : rrWay;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept && !isHit) begin
                    nextState = anyInvalid ? FILL : SELECT;
                end
            end
            SELECT: begin
                if (selDone) begin
                    nextState = ((dirtyQ & selVictim) != '0) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (wbReady) begin
                    nextState = FILL;
                end
            end
            FILL: begin
                if (fillDone) begin
                    nextState = ALLOC;
                end
            end
            ALLOC:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addrQ   <= '0;
            dirtyQ  <= '0;
            victimQ <= '0;
            hitQ    <= '0;
            waitCnt <= '0;
            rrPtr   <= '0;
            errQ    <= '0;
        end else begin
            hitQ <= '0;
            if (accept) begin
                addrQ   <= reqAddr;
                dirtyQ  <= dirtyWays;
                waitCnt <= '0;
                if (isHit) begin
                    hitQ <= hitSel;
                    if (hitMulti) begin
                        errQ[0] <= 1'b1;
                    end
                end else if (anyInvalid) begin
                    victimQ <= invalidSel;
                end
            end
            if (state == SELECT) begin
                if (evictionReady && !targetOk) begin
                    errQ[1] <= 1'b1;
                end
                if (selDone) begin
                    victimQ <= selVictim;
                end else begin
                    waitCnt <= waitCnt + CNT_W'(1);
                end
                if (timedOut) begin
                    errQ[2] <= 1'b1;
                    rrPtr   <= (rrPtr == RR_W'(NUM_WAYS - 1)) ? '0 : rrPtr + RR_W'(1);
                end
            end
        end
    end

    always_comb begin
        reqReady    = (state == IDLE);
        wbValid     = (state == WRITEBACK);
        fillValid   = (state == FILL);
        allocateWay = (state == ALLOC) ? victimQ : '0;
        hitWay      = hitQ;
        respValid   = (hitQ != '0) || (state == ALLOC);
        respHit     = (hitQ != '0);
        respWay     = (state == ALLOC) ? victimQ : hitQ;
    end

    assign fillAddr  = addrQ;
    assign victimWay = victimQ;
    assign errFlags  = errQ;

endmodule
